i2c_ioexp_target: RTL and testbench
===================================

# i2c_ioexp_target

I2C target (responder) emulating a 16-bit two-port I/O expander register file: 7-bit address, 8-bit register pointer, paired auto-increment. It answers the multi-byte register writes and pointer-then-read transactions issued by the board configuration loaders. It drives the emulated output-port and direction registers onto fabric signals. It serves as the in-fabric stand-in for the physical expander in loopback tests and as the bench responder for loader verification.

## Interface
Parameters:
- TARGET_ADDR, 7'h20, 7-bit bus address answered; any other address is ignored.
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i; minimum 2.

Ports:
- clk  in  1  system clock; must be ≥ 16× SCL frequency.
- rst  in  1  reset: synchronous, active-high; clock clk.
- scl_i  in  1  SCL line state, asynchronous.
- sda_i  in  1  SDA line state, asynchronous.
- sda_o  out  1  SDA drive: 0 pulls low, 1 releases.
- sda_t  out  1  tristate control, equals sda_o.
- port_in  in  16  input pins; reg 0 = [7:0], reg 1 = [15:8].
- port_out  out  16  {reg3, reg2}.
- port_cfg  out  16  {reg7, reg6}; 1 = pin is input.
- reg_wr  out  1  one-cycle pulse per committed register write.
- reg_wr_idx  out  3  index written, valid with reg_wr.
- busy  out  1  high from START until STOP.

## Operation
- Register map: 0/1 input (RO, = port_in XOR polarity), 2/3 output (reset 0xFF), 4/5 polarity (reset 0x00), 6/7 config (reset 0xFF). Writes to 0/1 are ACKed and discarded; reg_wr does not pulse.
- Pointer: 3 bits, taken from pointer byte [2:0], upper bits ignored; reset 0. Retained across repeated START and STOP.
- Auto-increment: after each data byte, pointer[0] toggles; pointer[2:1] unchanged (pairs wrap 3→2, 7→6).
- FSM: IDLE → (START) ADDR → ADDR_ACK → PTR → PTR_ACK → WDATA ↔ WDATA_ACK; ADDR_ACK with R/W=1 → RDATA ↔ RDATA_ACK; mismatch or master NACK → IGNORE.
- START, including repeated START, from any state → ADDR, bit counter cleared. STOP from any state → IDLE, sda_o released.
- Address match: drive ACK (sda_o=0) for the 9th clock. Mismatch: no ACK → IGNORE.
- Write data: byte complete on 8th rising SCL edge. Commit at the following SCL falling edge (reg_wr pulse, same cycle as ACK drive begins), then advance pointer.
- Read: byte loaded on the falling SCL edge ending ADDR_ACK/RDATA_ACK. Input registers sample port_in at load. MSB first. Master ACK (SDA low at 9th rising edge) → next byte. NACK → IGNORE.
- STOP or START mid-byte: partial byte discarded, no commit, pointer unchanged.
- busy = 0 and sda_o = 1 in IDLE and IGNORE-after-STOP.

## Timing
- Reset values: sda_o=1, sda_t=1, port_out=16'hFFFF, port_cfg=16'hFFFF, reg_wr=0, reg_wr_idx=0, busy=0; FSM IDLE; pointer 0.
- Input latency: SYNC_STAGES cycles plus 1 edge-detect cycle (plus 2 with filter).
- sda_o updates 1 cycle after detected SCL fall, never while detected SCL is high except on STOP release.
- START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both are evaluated before bit sampling in the same cycle.
- port_out/port_cfg update the cycle after reg_wr.
- rst mid-transaction: immediate IDLE, SDA released, registers to reset values. Bus traffic is ignored until the next START.

## Configuration
- I2C_IOEXP_TARGET_FILTER_EN defined: 3-sample majority filter after the synchronizer on SCL and SDA; +2 cycles latency; rejects single-cycle glitches.
- Undefined: synchronizer output used directly; a single-cycle glitch may be seen as an edge.

## Structure
- Package i2c_ioexp_pkg: register index constants (REG_IN0..REG_CFG1), reset value constants, FSM state enum type.
- Sub-module i2c_tgt_line_cond: synchronizer, optional filter, SCL rise/fall and START/STOP detection. Outputs are one-cycle strobes.
- Top holds FSM, shift register, bit counter, pointer, register file.

## Test plan
- Write 0x40,0x02,0x60,STOP → ACK on all 3 bytes; reg_wr at idx 2; port_out[7:0]=0x60; port_out[15:8]=0xFF.
- Write 0x40,0x06,0x97,0x5A → cfg0=0x97, cfg1=0x5A; port_cfg=16'h5A97; two reg_wr pulses (idx 6, 7).
- Write 0x40,0x01; repeated START; 0x41, read 3 bytes with ACK,ACK,NACK; port_in=16'hA55A, pol1=0x0F → reads 0xAA,0x5A,0xAA.
- Address 0x42 → no ACK; sda_o stays 1 through STOP; no register change.
- STOP after 4 data bits of write → no reg_wr, pointer unchanged; next read returns prior value.
- rst asserted during RDATA with sda_o=0 → sda_o=1 next cycle; port_out=16'hFFFF; busy=0.

Source files
------------

// File: rtl/i2c_ioexp_pkg.sv
// Shared register indices, reset values, FSM state type and pointer helper
// for the I2C two-port I/O-expander target.
package i2c_ioexp_pkg;

    localparam logic [2:0] REG_IN0  = 3'd0;
    localparam logic [2:0] REG_IN1  = 3'd1;
    localparam logic [2:0] REG_OUT0 = 3'd2;
    localparam logic [2:0] REG_OUT1 = 3'd3;
    localparam logic [2:0] REG_POL0 = 3'd4;
    localparam logic [2:0] REG_POL1 = 3'd5;
    localparam logic [2:0] REG_CFG0 = 3'd6;
    localparam logic [2:0] REG_CFG1 = 3'd7;

    localparam logic [7:0] OUT_RST = 8'hFF;
    localparam logic [7:0] POL_RST = 8'h00;
    localparam logic [7:0] CFG_RST = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    // Pairs wrap: only the low pointer bit moves between data bytes
    function automatic logic [2:0] ptr_next(input logic [2:0] ptr);
        return {ptr[2:1], ~ptr[0]};
    endfunction

endpackage

// File: rtl/i2c_tgt_line_cond.sv
// SCL/SDA conditioning: synchronizer, optional majority filter (macro
// I2C_IOEXP_TARGET_FILTER_EN), and one-cycle SCL edge / START / STOP strobes.
module i2c_tgt_line_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_lvl
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_cond_s;
    logic                   sda_cond_s;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic                   scl_rise_r;
    logic                   scl_fall_r;
    logic                   start_r;
    logic                   stop_r;
    logic                   sda_lvl_r;

    // Synchronizer chains; reset to the released (high) bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_IOEXP_TARGET_FILTER_EN
    logic [1:0] scl_hist_r;
    logic [1:0] sda_hist_r;
    logic       scl_filt_r;
    logic       sda_filt_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Three-sample majority vote drops single-cycle glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_r <= 2'b11;
            sda_hist_r <= 2'b11;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            scl_hist_r <= {scl_hist_r[0], scl_sync_r[SYNC_STAGES-1]};
            sda_hist_r <= {sda_hist_r[0], sda_sync_r[SYNC_STAGES-1]};
            scl_filt_r <= maj3(scl_sync_r[SYNC_STAGES-1], scl_hist_r[0], scl_hist_r[1]);
            sda_filt_r <= maj3(sda_sync_r[SYNC_STAGES-1], sda_hist_r[0], sda_hist_r[1]);
        end
    end

    assign scl_cond_s = scl_filt_r;
    assign sda_cond_s = sda_filt_r;
`else
    assign scl_cond_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_cond_s = sda_sync_r[SYNC_STAGES-1];
`endif

    // Edge and bus-condition strobes, with the SDA level aligned to them
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            sda_lvl_r  <= 1'b1;
        end else begin
            scl_prev_r <= scl_cond_s;
            sda_prev_r <= sda_cond_s;
            scl_rise_r <= scl_cond_s & ~scl_prev_r;
            scl_fall_r <= ~scl_cond_s & scl_prev_r;
            start_r    <= scl_cond_s & scl_prev_r & sda_prev_r & ~sda_cond_s;
            stop_r     <= scl_cond_s & scl_prev_r & ~sda_prev_r & sda_cond_s;
            sda_lvl_r  <= sda_cond_s;
        end
    end

    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start_det = start_r;
    assign stop_det  = stop_r;
    assign sda_lvl   = sda_lvl_r;

endmodule

// File: rtl/i2c_ioexp_target.sv
// I2C target emulating a 16-bit two-port I/O expander (8 byte registers).
// Optional input glitch filter: define I2C_IOEXP_TARGET_FILTER_EN.
module i2c_ioexp_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    input  logic [15:0] port_in,
    output logic [15:0] port_out,
    output logic [15:0] port_cfg,
    output logic        reg_wr,
    output logic [2:0]  reg_wr_idx,
    output logic        busy
);
    import i2c_ioexp_pkg::*;

    logic        scl_rise_s;
    logic        scl_fall_s;
    logic        start_s;
    logic        stop_s;
    logic        sda_s;
    logic        bit_in_s;
    logic        byte_end_s;
    logic [7:0]  rd_byte_s;

    state_t      state_r;
    logic [3:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [2:0]  ptr_r;
    logic        ack_r;
    logic        sda_o_r;
    logic        busy_r;
    logic        reg_wr_r;
    logic [2:0]  reg_wr_idx_r;
    logic [7:0]  out_r [2];
    logic [7:0]  pol_r [2];
    logic [7:0]  cfg_r [2];
    logic [15:0] port_out_r;
    logic [15:0] port_cfg_r;

    i2c_tgt_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_s),
        .stop_det  (stop_s),
        .sda_lvl   (sda_s)
    );

    // A bit counter of 8 means a full byte is in; the next fall ends it
    assign bit_in_s   = scl_rise_s & (bit_cnt_r < 4'd8);
    assign byte_end_s = scl_fall_s & (bit_cnt_r == 4'd8);

    // Read-back mux; input registers see live pins through the polarity mask
    always_comb begin
        rd_byte_s = 8'h00;
        case (ptr_r)
            REG_IN0:            rd_byte_s = port_in[7:0] ^ pol_r[0];
            REG_IN1:            rd_byte_s = port_in[15:8] ^ pol_r[1];
            REG_OUT0, REG_OUT1: rd_byte_s = out_r[ptr_r[0]];
            REG_POL0, REG_POL1: rd_byte_s = pol_r[ptr_r[0]];
            REG_CFG0, REG_CFG1: rd_byte_s = cfg_r[ptr_r[0]];
            default:            rd_byte_s = 8'h00;
        endcase
    end

    // Protocol FSM, shift register, pointer, register file and SDA drive
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 4'd0;
            shift_r      <= 8'h00;
            ptr_r        <= 3'd0;
            ack_r        <= 1'b0;
            sda_o_r      <= 1'b1;
            busy_r       <= 1'b0;
            reg_wr_r     <= 1'b0;
            reg_wr_idx_r <= 3'd0;
            for (int i = 0; i < 2; i++) begin
                out_r[i] <= OUT_RST;
                pol_r[i] <= POL_RST;
                cfg_r[i] <= CFG_RST;
            end
        end else begin
            reg_wr_r <= 1'b0;
            if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                sda_o_r   <= 1'b1;
                busy_r    <= 1'b0;
            end else if (start_s) begin
                state_r   <= ST_ADDR;
                bit_cnt_r <= 4'd0;
                sda_o_r   <= 1'b1;
                busy_r    <= 1'b1;
            end else begin
                case (state_r)
                    ST_ADDR: begin
                        if (bit_in_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (byte_end_s) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_r[7:1] == TARGET_ADDR) begin
                                state_r <= ST_ADDR_ACK;
                                sda_o_r <= 1'b0;
                            end else begin
                                state_r <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (shift_r[0]) begin
                                state_r <= ST_RDATA;
                                shift_r <= rd_byte_s;
                                sda_o_r <= rd_byte_s[7];
                            end else begin
                                state_r <= ST_PTR;
                                sda_o_r <= 1'b1;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (bit_in_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (byte_end_s) begin
                            bit_cnt_r <= 4'd0;
                            ptr_r     <= shift_r[2:0];
                            state_r   <= ST_PTR_ACK;
                            sda_o_r   <= 1'b0;
                        end
                    end
                    ST_WDATA: begin
                        if (bit_in_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (byte_end_s) begin
                            bit_cnt_r    <= 4'd0;
                            state_r      <= ST_WDATA_ACK;
                            sda_o_r      <= 1'b0;
                            ptr_r        <= ptr_next(ptr_r);
                            reg_wr_idx_r <= ptr_r;
                            case (ptr_r)
                                REG_OUT0, REG_OUT1: begin
                                    out_r[ptr_r[0]] <= shift_r;
                                    reg_wr_r        <= 1'b1;
                                end
                                REG_POL0, REG_POL1: begin
                                    pol_r[ptr_r[0]] <= shift_r;
                                    reg_wr_r        <= 1'b1;
                                end
                                REG_CFG0, REG_CFG1: begin
                                    cfg_r[ptr_r[0]] <= shift_r;
                                    reg_wr_r        <= 1'b1;
                                end
                                default: reg_wr_r <= 1'b0;
                            endcase
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall_s) begin
                            state_r <= ST_WDATA;
                            sda_o_r <= 1'b1;
                        end
                    end
                    ST_RDATA: begin
                        if (bit_in_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (byte_end_s) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_RDATA_ACK;
                            sda_o_r   <= 1'b1;
                            ptr_r     <= ptr_next(ptr_r);
                        end else if (scl_fall_s && (bit_cnt_r != 4'd0)) begin
                            shift_r <= {shift_r[6:0], 1'b0};
                            sda_o_r <= shift_r[6];
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise_s) begin
                            ack_r <= ~sda_s;
                        end else if (scl_fall_s) begin
                            if (ack_r) begin
                                state_r <= ST_RDATA;
                                shift_r <= rd_byte_s;
                                sda_o_r <= rd_byte_s[7];
                            end else begin
                                state_r <= ST_IGNORE;
                                sda_o_r <= 1'b1;
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE: state_r <= state_r;
                    default: begin
                        state_r <= ST_IDLE;
                        sda_o_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Fabric copies lag the register file by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            port_out_r <= {OUT_RST, OUT_RST};
            port_cfg_r <= {CFG_RST, CFG_RST};
        end else begin
            port_out_r <= {out_r[1], out_r[0]};
            port_cfg_r <= {cfg_r[1], cfg_r[0]};
        end
    end

    assign sda_o      = sda_o_r;
    assign sda_t      = sda_o_r;
    assign port_out   = port_out_r;
    assign port_cfg   = port_cfg_r;
    assign reg_wr     = reg_wr_r;
    assign reg_wr_idx = reg_wr_idx_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_i2c_ioexp_target.sv
// Directed plus randomized bench for i2c_ioexp_target with a bit-banged
// I2C master and a register-map reference model.
module tb_i2c_ioexp_target;

    localparam int         Q    = 8;
    localparam logic [6:0] ADDR = 7'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_scl;
    logic        m_sda;
    logic        bus_sda;
    logic        sda_o;
    logic        sda_t;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic [15:0] port_cfg;
    logic        reg_wr;
    logic [2:0]  reg_wr_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_reg [8];
    logic [2:0] m_ptr;
    int         exp_wr[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    logic [2:0] wr_log [1024];
    int         wr_cnt  = 0;
    int         wr_rd   = 0;
    int         low_cnt = 0;

    assign bus_sda = m_sda & sda_o;

    always #5 clk = ~clk;

    i2c_ioexp_target #(.TARGET_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (m_scl),
        .sda_i      (bus_sda),
        .sda_o      (sda_o),
        .sda_t      (sda_t),
        .port_in    (port_in),
        .port_out   (port_out),
        .port_cfg   (port_cfg),
        .reg_wr     (reg_wr),
        .reg_wr_idx (reg_wr_idx),
        .busy       (busy)
    );

    // Log write pulses and count cycles where the target holds SDA low
    always @(negedge clk) begin
        if (reg_wr) begin
            wr_log[wr_cnt % 1024] <= reg_wr_idx;
            wr_cnt <= wr_cnt + 1;
        end
        if (!sda_o) low_cnt <= low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_reg[2] = 8'hFF; m_reg[3] = 8'hFF;
        m_reg[6] = 8'hFF; m_reg[7] = 8'hFF;
        m_ptr = 3'd0;
    endtask

    function automatic logic [7:0] model_rd(input logic [2:0] idx);
        if (idx == 3'd0) return port_in[7:0] ^ m_reg[4];
        else if (idx == 3'd1) return port_in[15:8] ^ m_reg[5];
        else return m_reg[idx];
    endfunction

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        b = bus_sda;  tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~mack);
    endtask

    task automatic check_wr(input string tag);
        check({tag, "_wrcnt"}, wr_cnt - wr_rd, exp_wr.size());
        for (int k = 0; k < exp_wr.size(); k++)
            check({tag, "_wridx"}, {29'd0, wr_log[(wr_rd + k) % 1024]}, exp_wr[k]);
        wr_rd = wr_cnt;
        exp_wr.delete();
    endtask

    // Pointer write followed by every byte in txq
    task automatic wr_txn(input logic [7:0] ptr, input string tag);
        logic ack;
        i2c_start();
        send_byte({ADDR, 1'b0}, ack); check({tag, "_aack"}, ack, 1'b1);
        send_byte(ptr, ack);          check({tag, "_pack"}, ack, 1'b1);
        m_ptr = ptr[2:0];
        for (int k = 0; k < txq.size(); k++) begin
            send_byte(txq[k], ack);
            check({tag, "_dack"}, ack, 1'b1);
            if (m_ptr >= 3'd2) begin
                m_reg[m_ptr] = txq[k];
                exp_wr.push_back(int'(m_ptr));
            end
            m_ptr = m_ptr ^ 3'd1;
        end
        i2c_stop();
        check_wr(tag);
        check({tag, "_port_out"}, port_out, {m_reg[3], m_reg[2]});
        check({tag, "_port_cfg"}, port_cfg, {m_reg[7], m_reg[6]});
    endtask

    // Optional pointer set + repeated START, then n reads (last one NACKed)
    task automatic rd_txn(input logic set_ptr, input logic [7:0] ptr, input int n, input string tag);
        logic       ack;
        logic [7:0] d;
        rxq.delete();
        i2c_start();
        if (set_ptr) begin
            send_byte({ADDR, 1'b0}, ack); check({tag, "_wack"}, ack, 1'b1);
            send_byte(ptr, ack);          check({tag, "_pack"}, ack, 1'b1);
            m_ptr = ptr[2:0];
            i2c_start();
        end
        send_byte({ADDR, 1'b1}, ack); check({tag, "_rack"}, ack, 1'b1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, d);
            check({tag, "_data"}, d, model_rd(m_ptr));
            rxq.push_back(d);
            m_ptr = m_ptr ^ 3'd1;
        end
        i2c_stop();
        check_wr(tag);
    endtask

    initial begin
        logic ack;
        int   snap;
        int   n;

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; port_in = 16'h0000;
        model_reset();
        tick(5);
        check("rst_sda_o", sda_o, 1'b1);
        check("rst_sda_t", sda_t, 1'b1);
        check("rst_port_out", port_out, 16'hFFFF);
        check("rst_port_cfg", port_cfg, 16'hFFFF);
        check("rst_reg_wr", reg_wr, 1'b0);
        check("rst_reg_wr_idx", reg_wr_idx, 3'd0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(2 * Q);

        // Single output write
        txq = {8'h60};
        wr_txn(8'h02, "t1");
        check("t1_port_out_const", port_out, 16'hFF60);

        // Config pair write
        txq = {8'h97, 8'h5A};
        wr_txn(8'h06, "t2");
        check("t2_port_cfg_const", port_cfg, 16'h5A97);

        // Polarity on port 1, then pointer + repeated START + 3 reads
        txq = {8'h0F};
        wr_txn(8'h05, "t3pol");
        port_in = 16'hA55A;
        rd_txn(1'b1, 8'h01, 3, "t3");
        check("t3_b0", rxq[0], 8'hAA);
        check("t3_b1", rxq[1], 8'h5A);
        check("t3_b2", rxq[2], 8'hAA);

        // Foreign address: no ACK, no drive, no writes
        snap = low_cnt;
        i2c_start();
        check("t4_busy_hi", busy, 1'b1);
        send_byte(8'h42, ack); check("t4_ack_addr", ack, 1'b0);
        send_byte(8'h03, ack); check("t4_ack_b1", ack, 1'b0);
        send_byte(8'h11, ack); check("t4_ack_b2", ack, 1'b0);
        i2c_stop();
        check("t4_busy_lo", busy, 1'b0);
        check("t4_sda_low_cycles", low_cnt - snap, 0);
        check_wr("t4");
        check("t4_port_out", port_out, {m_reg[3], m_reg[2]});

        // STOP after 4 data bits: discarded, pointer stays at 3
        txq = {8'h3C};
        wr_txn(8'h03, "t5pre");
        i2c_start();
        send_byte({ADDR, 1'b0}, ack); check("t5_aack", ack, 1'b1);
        send_byte(8'h03, ack);        check("t5_pack", ack, 1'b1);
        m_ptr = 3'd3;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        check_wr("t5");
        rd_txn(1'b0, 8'h00, 1, "t5rd");
        check("t5_rd_const", rxq[0], 8'h3C);

        // Randomized writes and reads against the model
        for (int it = 0; it < 10; it++) begin
            port_in = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(1, 4);
                txq.delete();
                for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
                wr_txn(8'($urandom), "rnd_wr");
            end else begin
                rd_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 4), "rnd_rd");
            end
        end

        // Reset while the target is driving a 0 data bit
        txq = {8'h00};
        wr_txn(8'h02, "t6pre");
        i2c_start();
        send_byte({ADDR, 1'b0}, ack); check("t6_wack", ack, 1'b1);
        send_byte(8'h02, ack);        check("t6_pack", ack, 1'b1);
        i2c_start();
        send_byte({ADDR, 1'b1}, ack); check("t6_rack", ack, 1'b1);
        check("t6_drive_low", sda_o, 1'b0);
        rst = 1'b1;
        tick(1);
        check("t6_sda_o", sda_o, 1'b1);
        check("t6_sda_t", sda_t, 1'b1);
        check("t6_port_out", port_out, 16'hFFFF);
        check("t6_port_cfg", port_cfg, 16'hFFFF);
        check("t6_busy", busy, 1'b0);
        rst = 1'b0;
        model_reset();
        m_sda = 1'b1;
        i2c_stop();
        port_in = 16'h3CC3;
        rd_txn(1'b0, 8'h00, 2, "t6post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
